// File: rtl/chan_mux_rr_pkg.sv
// Shared mode encodings for the channel multiplexer.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/chan_mux_rr_if.sv
// Producer-lane / consumer handshake bundle for chan_mux_rr.
interface chan_mux_rr_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEL_W = $clog2(N_CH)
);

    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [SEL_W-1:0]      out_ch;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );

endinterface

// File: rtl/chan_mux_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins, wrapping at N_CH-1.
module rr_arbiter #(
    parameter int unsigned N_CH = 4,
    localparam int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             en,
    output logic [N_CH-1:0]  gnt,
    output logic [SEL_W-1:0] gnt_idx
);

    logic        found;
    int unsigned idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            idx = (32'(ptr) + k) % N_CH;
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = SEL_W'(idx);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chan_mux_rr.sv
// N-channel registered multiplexer with fixed-select or round-robin channel choice.
module chan_mux_rr
    import mux_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned SEL_W = $clog2(N_CH)
) (
    input logic          clk,
    input logic          rst,
    chan_mux_rr_if.slave bus
);

    logic             load;
    logic             en;
    logic             xfer;
    logic [N_CH-1:0]  rr_gnt;
    logic [N_CH-1:0]  fix_gnt;
    logic [N_CH-1:0]  gnt;
    logic [SEL_W-1:0] rr_idx;
    logic [SEL_W-1:0] g;
    logic [WIDTH-1:0] g_data;

    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] ch_q;
    logic             valid_q;
    logic [SEL_W-1:0] ptr_q;

    rr_arbiter #(
        .N_CH(N_CH)
    ) u_arb (
        .req    (bus.in_valid),
        .ptr    (ptr_q),
        .en     (en && (bus.mode == MODE_RR)),
        .gnt    (rr_gnt),
        .gnt_idx(rr_idx)
    );

    always_comb begin
        load    = ~valid_q | bus.out_ready;
        en      = load & ~rst;
        fix_gnt = '0;
        // Comparing against each legal index means an out-of-range sel simply grants nothing.
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (en && (bus.sel == SEL_W'(i)) && bus.in_valid[i]) begin
                fix_gnt[i] = 1'b1;
            end
        end
        if (bus.mode == MODE_RR) begin
            gnt = rr_gnt;
            g   = rr_idx;
        end else begin
            gnt = fix_gnt;
            g   = bus.sel;
        end
        xfer   = |gnt;
        g_data = bus.in_data[int'(g) * int'(WIDTH) +: WIDTH];
        bus.in_ready = gnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else if (load) begin
            if (xfer) begin
                data_q  <= g_data;
                ch_q    <= g;
                valid_q <= 1'b1;
                if (bus.mode == MODE_RR) begin
                    ptr_q <= (int'(g) == int'(N_CH) - 1) ? '0 : g + SEL_W'(1);
                end
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_chan_mux_rr.sv
// Scoreboard bench for chan_mux_rr: directed streams push expected words, a monitor checks pops.
module tb_chan_mux_rr;
    import mux_pkg::*;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    chan_mux_rr_if #(.N_CH(4), .WIDTH(8)) bus ();

    chan_mux_rr #(
        .N_CH (4),
        .WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    int seq_rr[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
    int seq_fx[8]  = '{2, 2, 2, 2, 2, 2, 2, 2};
    int seq_alt[8] = '{1, 3, 1, 3, 1, 3, 1, 3};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // A word is consumed at the posedge following a negedge where valid and ready are both high.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got ch %0d data %0h expected none",
                         bus.out_ch, bus.out_data);
            end else begin
                e = sb.pop_front();
                check("out_ch", 32'(bus.out_ch), 32'(e.ch));
                check("out_data", 32'(bus.out_data), 32'(e.data));
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input logic [7:0] data);
        exp_t e;
        e.ch   = ch[1:0];
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic stream(input int n, input int seq[8]);
        for (int i = 0; i < n; i++) begin
            push(seq[i], 8'(8'hA0 + seq[i]));
            cycle();
        end
        bus.in_valid = 4'b0000;
        cycle();
        cycle();
    endtask

    initial begin
        rst           = 1'b1;
        bus.mode      = MODE_RR;
        bus.sel       = 2'd0;
        bus.in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;

        // Reset holds everything quiet even with every lane requesting.
        cycle();
        cycle();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_grant", 32'(bus.in_ready), 32'b0001);

        // Round-robin over all lanes, wrapping 3 -> 0.
        stream(8, seq_rr);

        // Fixed select on lane 2.
        bus.mode     = MODE_FIXED;
        bus.sel      = 2'd2;
        bus.in_valid = 4'b1111;
        #1;
        check("fixed_in_ready", 32'(bus.in_ready), 32'b0100);
        stream(4, seq_fx);

        // Round-robin skips idle lanes 0 and 2.
        bus.mode     = MODE_RR;
        bus.in_valid = 4'b1010;
        #1;
        check("rr_sparse_in_ready", 32'(bus.in_ready), 32'b0010);
        stream(4, seq_alt);

        // Backpressure: hold a word for 3 cycles, then pop and load in the same cycle.
        bus.mode     = MODE_FIXED;
        bus.sel      = 2'd1;
        bus.in_data  = {8'hA3, 8'hA2, 8'h10, 8'hA0};
        bus.in_valid = 4'b0010;
        push(1, 8'h10);
        cycle();
        bus.out_ready = 1'b0;
        bus.in_data   = {8'hA3, 8'hA2, 8'h11, 8'hA0};
        push(1, 8'h11);
        #1;
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_out_data", 32'(bus.out_data), 32'h10);
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_in_ready_hold", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        cycle();
        bus.in_valid = 4'b0000;
        bus.in_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        cycle();
        cycle();

        // Reset while a word is held: it must vanish and ptr must return to 0.
        bus.mode      = MODE_RR;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b0;
        #1;
        check("pre_hold_grant", 32'(bus.in_ready), 32'b0001);
        cycle();
        bus.in_valid = 4'b0000;
        cycle();
        check("held_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        cycle();
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_out_data", 32'(bus.out_data), 32'd0);
        rst           = 1'b0;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        #1;
        check("ptr_after_rst", 32'(bus.in_ready), 32'b0001);
        stream(1, seq_rr);

        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            cycle();
        end
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
